csi_pckthandler_mp: RTL
=======================

Name: csi_pckthandler_mp

Overview:
Parametrised successor to the CSI-2 packet handler. It sits after the lane merger and byte aligner.
- Accepts an aligned byte stream, BYTES_PER_BEAT bytes per cycle.
- Decodes and ECC-checks packet headers, filters by virtual channel and data type.
- Strips headers and CRC; emits pixel payload with byte-keep, frame-active and line-valid flags.
- Reports header, length and short-packet events as sticky or pulsed status.

Parameters:
BYTES_PER_BEAT, 2, bytes per input beat; legal values 2 or 4.
VC_EN, 4'b0001, bitmask of accepted virtual channels 0..3.
PIXEL_DT, 6'h2B, long-packet data type forwarded as pixels; all other long packets are consumed silently.
WC_MAX, 16'd8192, word counts above this are treated as a header error.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
din  in  8*BYTES_PER_BEAT  aligned byte stream; byte 0 in bits [7:0]
din_valid  in  1  high for the whole high-speed burst; falling edge ends the packet
dout  out  8*BYTES_PER_BEAT  payload bytes, same byte order as din
dout_keep  out  BYTES_PER_BEAT  per-byte valid; all ones except on the last beat
dout_valid  out  1  dout/dout_keep qualified
dout_vc  out  2  virtual channel of the current payload
fr_active  out  1  high from accepted Frame Start to accepted Frame End
fr_valid  out  1  line valid; equals dout_valid for PIXEL_DT payload
hdr_err  out  1  one-cycle pulse on ECC mismatch or WC > WC_MAX
len_err  out  1  one-cycle pulse when din_valid drops before WC payload bytes have arrived
err_cnt  out  8  saturating count of hdr_err + len_err events

Behaviour:
- Reset (reset=0, async): dout=0, dout_keep=0, dout_valid=0, dout_vc=0, fr_active=0, fr_valid=0, hdr_err=0, len_err=0, err_cnt=0, state=IDLE.
- Packets begin at byte 0 of the first valid beat after din_valid rises. The aligner guarantees this.
- Header bytes: DI = {VC[7:6], DT[5:0]}, WC_lo, WC_hi, ECC.
- ECC check: the 6-bit CSI-2 ECC is computed over 24 header bits and compared against ECC[5:0]. Mismatch means the packet is dropped. No single-bit correction.
- States:
  - IDLE: on din_valid go to HDR.
  - HDR: collect 4 header bytes. This takes 1 beat (BPB=4) or 2 beats (BPB=2). On completion, check ECC and WC:
    - Error: pulse hdr_err, go to DRAIN.
    - Short DT (0x00–0x0F): action below, then go to DRAIN.
    - Long DT: go to PAYLOAD if VC_EN[VC] and DT==PIXEL_DT, else go to SKIP.
  - PAYLOAD: per valid beat, forward the bytes and decrement the remaining count by BYTES_PER_BEAT. On the last beat, set dout_keep[i]=1 for i < remaining bytes, then go to DRAIN.
  - SKIP: same counting as PAYLOAD, with no output.
  - DRAIN: discard CRC and filler until din_valid=0, then go to IDLE.
- Short-packet actions (only when VC_EN[VC]=1):
  - DT=0x00 (Frame Start) sets fr_active.
  - DT=0x01 (Frame End) clears fr_active.
  - Line start/end and generic short packets are ignored.
- Latency: dout, dout_keep, dout_valid and fr_valid are registered, 1 cycle after the accepting din beat. Header beats never produce output.
- WC=0 long packet: go straight to DRAIN with no output.
- din_valid falls in HDR/PAYLOAD/SKIP: pulse len_err (HDR included), go to IDLE, no dout beat that cycle.
- din_valid falls in DRAIN: normal completion, no error.
- FS while fr_active=1: stays 1 (no error).
- FE while fr_active=0: stays 0.
- fr_active is unaffected by dropped packets.
- hdr_err and len_err never fire in the same cycle.
- err_cnt saturates at 255.
- Remaining-byte counter is 16 bits. Subtraction is clamped at 0, so it never wraps.

Decomposition:
- Package csi_pkg: DT constants (DT_FS=0x00, DT_FE=0x01, DT_LS=0x02, DT_LE=0x03), state enum, header struct {vc, dt, wc, ecc}, ecc_calc function.
- Sub-module csi_ecc_check: combinational; 24-bit header in, 6-bit received ECC in, ok flag out.

Test Plan:
1. BPB=2, VC_EN=1: FS header {00,00,00,ECC}, then long packet DT=0x2B, WC=6, payload 11..66, CRC, then FE → fr_active rises 1 cycle after the FS header beat. Three dout beats 2211/4433/6655 with keep=11 and fr_valid=1. fr_active falls after FE.
2. BPB=4, WC=6 → dout 44332211 (keep 1111), then 00006655 (keep 0011); CRC bytes never appear.
3. FS header with ECC bit 0 flipped → hdr_err pulses once, err_cnt=1, fr_active stays 0. The next good FS is accepted.
4. Long packet on VC=1 with VC_EN=4'b0001, and a DT=0x12 packet on VC=0 → no dout_valid, no errors.
5. WC=8, din_valid dropped after 4 payload bytes → len_err pulse, err_cnt+1, state returns to IDLE. The next packet decodes correctly.
6. Reset asserted mid-PAYLOAD → all outputs 0 immediately, without waiting for a clock edge. After release, an FS is accepted normally.

Source files
------------

// File: rtl/csi_pkg.sv
// Shared types and helpers for the CSI-2 packet handler: data-type codes,
// FSM states, the decoded header layout and the 6-bit header ECC generator.
package csi_pkg;

    localparam logic [5:0] DT_FS        = 6'h00;
    localparam logic [5:0] DT_FE        = 6'h01;
    localparam logic [5:0] DT_LS        = 6'h02;
    localparam logic [5:0] DT_LE        = 6'h03;
    localparam logic [5:0] DT_SHORT_MAX = 6'h0F;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR     = 3'd1,
        PAYLOAD = 3'd2,
        SKIP    = 3'd3,
        DRAIN   = 3'd4
    } csi_state_e;

    typedef struct packed {
        logic [1:0]  vc;
        logic [5:0]  dt;
        logic [15:0] wc;
        logic [7:0]  ecc;
    } csi_hdr_t;

    // d[7:0] is the DI byte, d[23:8] the word count; parity bits 6 and 7 are always zero.
    function automatic logic [5:0] ecc_calc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return p;
    endfunction

endpackage

// File: rtl/csi_ecc_check.sv
// Combinational header ECC comparison; flags whether the received ECC matches
// the ECC regenerated from the 24 header bits. Detection only, no correction.
module csi_ecc_check
    import csi_pkg::*;
(
    input  logic [23:0] hdr_data,
    input  logic [5:0]  ecc_rx,
    output logic        ecc_ok
);

    assign ecc_ok = (ecc_calc(hdr_data) == ecc_rx);

endmodule

// File: rtl/csi_pckthandler_mp.sv
// CSI-2 packet handler: decodes and checks headers from an aligned byte stream,
// forwards pixel payload with byte-keep and tracks frame/error status.
module csi_pckthandler_mp
    import csi_pkg::*;
#(
    parameter int unsigned BYTES_PER_BEAT = 32'd2,
    parameter logic [3:0]  VC_EN          = 4'b0001,
    parameter logic [5:0]  PIXEL_DT       = 6'h2B,
    parameter logic [15:0] WC_MAX         = 16'd8192
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [8*BYTES_PER_BEAT-1:0]   din,
    input  logic                          din_valid,
    output logic [8*BYTES_PER_BEAT-1:0]   dout,
    output logic [BYTES_PER_BEAT-1:0]     dout_keep,
    output logic                          dout_valid,
    output logic [1:0]                    dout_vc,
    output logic                          fr_active,
    output logic                          fr_valid,
    output logic                          hdr_err,
    output logic                          len_err,
    output logic [7:0]                    err_cnt
);

    localparam int unsigned DW    = 8 * BYTES_PER_BEAT;
    localparam logic [15:0] BPB_W = 16'(BYTES_PER_BEAT);

    csi_state_e            state_q, state_d;
    logic [15:0]           hdr_lo_q, hdr_lo_d;
    logic [15:0]           rem_q, rem_d;
    logic [1:0]            vc_q, vc_d;
    logic [DW-1:0]         dout_q, dout_d;
    logic [BYTES_PER_BEAT-1:0] keep_q, keep_d;
    logic                  dout_valid_q, dout_valid_d;
    logic [1:0]            dout_vc_q, dout_vc_d;
    logic                  fr_active_q, fr_active_d;
    logic                  fr_valid_q, fr_valid_d;
    logic                  hdr_err_q, hdr_err_d;
    logic                  len_err_q, len_err_d;
    logic [7:0]            err_cnt_q, err_cnt_d;

    logic [31:0]           din_ext_s;
    logic [31:0]           hdr_word_s;
    csi_hdr_t              hdr_s;
    logic                  ecc_ok_s;
    logic                  hdr_bad_s;
    logic                  hdr_done_s;
    logic                  ecc_spare_unused_s;
    logic [DW-1:0]         beat_data_s;
    logic [BYTES_PER_BEAT-1:0] beat_keep_s;

    // With two bytes per beat the header spans two beats; the first half is held in hdr_lo_q.
    assign din_ext_s  = 32'(din);
    assign hdr_word_s = (BYTES_PER_BEAT == 32'd4) ? din_ext_s : {din_ext_s[15:0], hdr_lo_q};
    assign hdr_s      = '{vc: hdr_word_s[7:6], dt: hdr_word_s[5:0],
                          wc: hdr_word_s[23:8], ecc: hdr_word_s[31:24]};
    assign ecc_spare_unused_s = ^hdr_s.ecc[7:6];
    assign hdr_bad_s  = !ecc_ok_s || (hdr_s.wc > WC_MAX);

    csi_ecc_check u_ecc (
        .hdr_data (hdr_word_s[23:0]),
        .ecc_rx   (hdr_s.ecc[5:0]),
        .ecc_ok   (ecc_ok_s)
    );

    // Payload lanes beyond the remaining byte count are masked and zeroed.
    always_comb begin
        beat_data_s = '0;
        beat_keep_s = '0;
        for (int i = 0; i < int'(BYTES_PER_BEAT); i++) begin
            if (rem_q > 16'(i)) begin
                beat_keep_s[i]      = 1'b1;
                beat_data_s[8*i +: 8] = din[8*i +: 8];
            end else begin
                beat_keep_s[i]      = 1'b0;
                beat_data_s[8*i +: 8] = 8'h00;
            end
        end
    end

    // Packet FSM next state and next values of every registered output.
    always_comb begin
        state_d      = state_q;
        hdr_lo_d     = hdr_lo_q;
        rem_d        = rem_q;
        vc_d         = vc_q;
        dout_d       = '0;
        keep_d       = '0;
        dout_valid_d = 1'b0;
        dout_vc_d    = dout_vc_q;
        fr_active_d  = fr_active_q;
        fr_valid_d   = 1'b0;
        hdr_err_d    = 1'b0;
        len_err_d    = 1'b0;
        hdr_done_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!din_valid) begin
                    state_d = IDLE;
                end else if (BYTES_PER_BEAT == 32'd4) begin
                    hdr_done_s = 1'b1;
                end else begin
                    hdr_lo_d = din_ext_s[15:0];
                    state_d  = HDR;
                end
            end
            HDR: begin
                if (din_valid) begin
                    hdr_done_s = 1'b1;
                end else begin
                    len_err_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            PAYLOAD, SKIP: begin
                if (!din_valid) begin
                    len_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    if (state_q == PAYLOAD) begin
                        dout_d       = beat_data_s;
                        keep_d       = beat_keep_s;
                        dout_valid_d = 1'b1;
                        fr_valid_d   = 1'b1;
                        dout_vc_d    = vc_q;
                    end else begin
                        dout_valid_d = 1'b0;
                    end
                    rem_d   = (rem_q > BPB_W) ? (rem_q - BPB_W) : 16'd0;
                    state_d = (rem_q > BPB_W) ? state_q : DRAIN;
                end
            end
            DRAIN: begin
                if (!din_valid) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase

        if (hdr_done_s) begin
            if (hdr_bad_s) begin
                hdr_err_d = 1'b1;
                state_d   = DRAIN;
            end else if (hdr_s.dt <= DT_SHORT_MAX) begin
                if (VC_EN[hdr_s.vc]) begin
                    case (hdr_s.dt)
                        DT_FS:        fr_active_d = 1'b1;
                        DT_FE:        fr_active_d = 1'b0;
                        DT_LS, DT_LE: fr_active_d = fr_active_q;
                        default:      fr_active_d = fr_active_q;
                    endcase
                end else begin
                    fr_active_d = fr_active_q;
                end
                state_d = DRAIN;
            end else if (hdr_s.wc == 16'd0) begin
                state_d = DRAIN;
            end else begin
                rem_d   = hdr_s.wc;
                vc_d    = hdr_s.vc;
                state_d = (VC_EN[hdr_s.vc] && (hdr_s.dt == PIXEL_DT)) ? PAYLOAD : SKIP;
            end
        end else begin
            hdr_err_d = 1'b0;
        end

        if ((hdr_err_d || len_err_d) && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            hdr_lo_q     <= 16'h0000;
            rem_q        <= 16'h0000;
            vc_q         <= 2'b00;
            dout_q       <= '0;
            keep_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_vc_q    <= 2'b00;
            fr_active_q  <= 1'b0;
            fr_valid_q   <= 1'b0;
            hdr_err_q    <= 1'b0;
            len_err_q    <= 1'b0;
            err_cnt_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            hdr_lo_q     <= hdr_lo_d;
            rem_q        <= rem_d;
            vc_q         <= vc_d;
            dout_q       <= dout_d;
            keep_q       <= keep_d;
            dout_valid_q <= dout_valid_d;
            dout_vc_q    <= dout_vc_d;
            fr_active_q  <= fr_active_d;
            fr_valid_q   <= fr_valid_d;
            hdr_err_q    <= hdr_err_d;
            len_err_q    <= len_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign dout       = dout_q;
    assign dout_keep  = keep_q;
    assign dout_valid = dout_valid_q;
    assign dout_vc    = dout_vc_q;
    assign fr_active  = fr_active_q;
    assign fr_valid   = fr_valid_q;
    assign hdr_err    = hdr_err_q;
    assign len_err    = len_err_q;
    assign err_cnt    = err_cnt_q;

endmodule
